// File: rtl/uv_rd_score_if.sv
// Candidate/result bundle between the UV rate stage feeder and the chroma RD scorer.
// The master drives the sweep and its candidates; the slave returns the winning mode.
interface uv_rd_score_if;
  logic        start;
  logic [15:0] lambda;
  logic        valid;
  logic [31:0] rate;
  logic [15:0] hdr;
  logic [31:0] disto;
  logic [31:0] sdisto;
  logic        busy;
  logic [2:0]  best_mode;
  logic [63:0] best_score;
  logic        done;

  modport master (
    output start, lambda, valid, rate, hdr, disto, sdisto,
    input  busy, best_mode, best_score, done
  );

  modport slave (
    input  start, lambda, valid, rate, hdr, disto, sdisto,
    output busy, best_mode, best_score, done
  );
endinterface

// File: rtl/uv_rd_score.sv
// Chroma RD scorer: score = (R+H)*lambda + RD_DISTO_MULT*(D+SD) over NUM_MODES
// candidates, with a three-stage pipeline and a strict-min picker (ties keep the lower mode).
module uv_rd_score #(
  parameter int NUM_MODES     = 4,
  parameter int RD_DISTO_MULT = 256
) (
  input logic         clk,
  input logic         rst,
  uv_rd_score_if.slave bus
);
  localparam int SH     = $clog2(RD_DISTO_MULT);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t              state;
  logic [2:0]          cnt;
  logic [15:0]         lam_r;
  logic                acc;
  // [0] S1 holds a candidate, [1] S2 holds a score, [2] running best just updated
  logic [STAGES:0]     vld_pipe;

  logic [32:0]         rh1, dsd1;
  logic [2:0]          tag1, tag2;
  logic [63:0]         score2;
  logic [63:0]         run_score;
  logic [2:0]          run_mode;

  assign acc = (state == COLLECT) && bus.valid && !bus.start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      lam_r          <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.best_mode  <= '0;
      bus.best_score <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.start) begin
        // start in any state (re)opens a sweep; an aborted sweep never reports
        state    <= COLLECT;
        cnt      <= '0;
        lam_r    <= bus.lambda;
        bus.busy <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          COLLECT:
            if (bus.valid) begin
              if (cnt == 3'(NUM_MODES - 1)) state <= DRAIN;
              else                          cnt   <= cnt + 3'd1;
            end
          DRAIN:
            if (vld_pipe[1:0] == '0) begin
              state          <= DONE;
              bus.done       <= 1'b1;
              bus.best_mode  <= run_mode;
              bus.best_score <= run_score;
            end
          DONE: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      run_score <= '1;
      run_mode  <= '0;
    end else if (bus.start) begin
      vld_pipe  <= '0;
      run_score <= '1;
      run_mode  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], acc};
      if (vld_pipe[1] && (score2 < run_score)) begin
        run_score <= score2;
        run_mode  <= tag2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      rh1  <= {1'b0, bus.rate} + {17'd0, bus.hdr};
      dsd1 <= {1'b0, bus.disto} + {1'b0, bus.sdisto};
      tag1 <= cnt;
    end
    if (vld_pipe[0]) begin
      score2 <= 64'(rh1) * 64'(lam_r) + (64'(dsd1) << SH);
      tag2   <= tag1;
    end
  end
endmodule

// File: tb/tb_uv_rd_score.sv
// Directed bench for uv_rd_score: basic pick, tie, width, gaps/strays, abort, reset.
module tb_uv_rd_score;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   d0;

  uv_rd_score_if ifc();

  uv_rd_score #(.NUM_MODES(4), .RD_DISTO_MULT(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ifc.done === 1'b1) n_done++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] lam);
    ifc.start  = 1'b1;
    ifc.lambda = lam;
    tick();
    ifc.start  = 1'b0;
  endtask

  task automatic beat(input logic [31:0] r, input logic [15:0] h, input logic [31:0] d, input logic [31:0] sd);
    ifc.valid = 1'b1; ifc.rate = r; ifc.hdr = h; ifc.disto = d; ifc.sdisto = sd;
    tick();
    ifc.valid = 1'b0;
  endtask

  task automatic basic4();
    beat(100, 10, 1000, 0);
    beat(50, 10, 900, 50);
    beat(0, 0, 2000, 0);
    beat(200, 20, 950, 0);
  endtask

  // called right after the edge that sampled the last beat
  task automatic expect_done(input string tag, input logic [2:0] m, input logic [63:0] s);
    tick(); chk({tag, ".done_t1"}, 64'(ifc.done), 64'd0);
    tick(); chk({tag, ".done_t2"}, 64'(ifc.done), 64'd0);
    tick();
    chk({tag, ".done_t3"}, 64'(ifc.done), 64'd1);
    chk({tag, ".mode"}, 64'(ifc.best_mode), 64'(m));
    chk({tag, ".score"}, ifc.best_score, s);
    chk({tag, ".busy_t3"}, 64'(ifc.busy), 64'd1);
    tick();
    chk({tag, ".done_t4"}, 64'(ifc.done), 64'd0);
    chk({tag, ".busy_t4"}, 64'(ifc.busy), 64'd0);
  endtask

  initial begin
    ifc.start = 1'b0; ifc.lambda = '0; ifc.valid = 1'b0;
    ifc.rate = '0; ifc.hdr = '0; ifc.disto = '0; ifc.sdisto = '0;
    tick(); tick();
    chk("rst.busy", 64'(ifc.busy), 64'd0);
    chk("rst.done", 64'(ifc.done), 64'd0);
    chk("rst.mode", 64'(ifc.best_mode), 64'd0);
    chk("rst.score", ifc.best_score, 64'd0);
    rst = 1'b0;
    tick();

    // basic pick
    d0 = n_done;
    go(16'd4);
    chk("basic.busy_rise", 64'(ifc.busy), 64'd1);
    basic4();
    expect_done("basic", 3'd1, 64'd243440);
    chk("basic.ndone", 64'(n_done - d0), 64'd1);

    // result holds through idle
    repeat (3) tick();
    chk("hold.score", ifc.best_score, 64'd243440);

    // tie keeps mode 0
    go(16'd1);
    repeat (4) beat(10, 0, 10, 0);
    expect_done("tie", 3'd0, 64'd2570);

    // full-width operands
    go(16'hFFFF);
    repeat (4) beat(32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_done("width", 3'd0, 64'd283673999769090);

    // stray beats in IDLE, gaps, stray beats after the last mode
    d0 = n_done;
    beat(0, 0, 0, 0);
    go(16'd4);
    beat(100, 10, 1000, 0);  repeat (3) tick();
    beat(50, 10, 900, 50);   repeat (2) tick();
    beat(0, 0, 2000, 0);     tick();
    beat(200, 20, 950, 0);
    ifc.valid = 1'b1; ifc.rate = 0; ifc.hdr = 0; ifc.disto = 0; ifc.sdisto = 0;
    expect_done("gap", 3'd1, 64'd243440);
    repeat (3) tick();
    ifc.valid = 1'b0;
    tick();
    chk("gap.ndone", 64'(n_done - d0), 64'd1);
    chk("gap.score_hold", ifc.best_score, 64'd243440);

    // abort after two beats with scores that would otherwise win
    d0 = n_done;
    go(16'd4);
    beat(0, 0, 0, 0);
    beat(0, 0, 0, 0);
    go(16'd4);
    basic4();
    expect_done("abort", 3'd1, 64'd243440);
    chk("abort.ndone", 64'(n_done - d0), 64'd1);

    // start+valid together drops that beat; swap the winner to mode 3
    ifc.valid = 1'b1; ifc.rate = 0; ifc.hdr = 0; ifc.disto = 0; ifc.sdisto = 0;
    go(16'd2);
    ifc.valid = 1'b0;
    beat(100, 10, 1000, 0);
    beat(50, 10, 900, 50);
    beat(0, 0, 2000, 0);
    beat(5, 0, 100, 0);
    expect_done("sv_drop", 3'd3, 64'd25610);

    // reset between beats 2 and 3
    d0 = n_done;
    go(16'd4);
    beat(100, 10, 1000, 0);
    beat(50, 10, 900, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.busy", 64'(ifc.busy), 64'd0);
    chk("mrst.done", 64'(ifc.done), 64'd0);
    chk("mrst.mode", 64'(ifc.best_mode), 64'd0);
    chk("mrst.score", ifc.best_score, 64'd0);
    beat(0, 0, 2000, 0);
    beat(200, 20, 950, 0);
    repeat (6) tick();
    chk("mrst.ndone", 64'(n_done - d0), 64'd0);
    go(16'd4);
    basic4();
    expect_done("post_rst", 3'd1, 64'd243440);

    // back-to-back: new start right after done
    go(16'd1);
    repeat (4) beat(10, 0, 10, 0);
    tick(); tick(); tick();
    chk("b2b.done", 64'(ifc.done), 64'd1);
    go(16'd4);
    chk("b2b.busy", 64'(ifc.busy), 64'd1);
    basic4();
    expect_done("b2b", 3'd1, 64'd243440);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
